// File: rtl/window_stream_gen_if.sv
// Handshake and configuration bundle for window_stream_gen.
// master = upstream/controller side, slave = the window generator.
interface window_stream_gen_if #(
    parameter int INW  = 16,
    parameter int CH   = 4,
    parameter int MAXK = 3,
    parameter int MAXW = 64,
    parameter int MAXH = 64,
    parameter int MAXS = 4
);
    localparam int KW = $clog2(MAXK + 1);
    localparam int WW = $clog2(MAXW + 1);
    localparam int HW = $clog2(MAXH + 1);
    localparam int SW = $clog2(MAXS + 1);

    logic                          clr;
    logic                          start;
    logic [KW-1:0]                 cfg_k;
    logic [WW-1:0]                 cfg_w;
    logic [HW-1:0]                 cfg_h;
    logic [SW-1:0]                 cfg_s;
    logic                          in_valid;
    logic                          in_ready;
    logic [CH*INW-1:0]             pixel_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [MAXK*MAXK*CH*INW-1:0]   window_out;
    logic                          frame_done;
    logic                          cfg_err;

    modport master (
        output clr, start, cfg_k, cfg_w, cfg_h, cfg_s, in_valid, pixel_in, out_ready,
        input  in_ready, out_valid, window_out, frame_done, cfg_err
    );
    modport slave (
        input  clr, start, cfg_k, cfg_w, cfg_h, cfg_s, in_valid, pixel_in, out_ready,
        output in_ready, out_valid, window_out, frame_done, cfg_err
    );
endinterface

// File: rtl/window_stream_gen.sv
// Raster pixel stream to KxK sliding windows with runtime K/W/H/stride.
// Optional macro WINDOW_OUTREG_EN adds an output slice plus skid slot (latency 2, registered in_ready).
module window_stream_gen #(
    parameter int INW  = 16,
    parameter int CH   = 4,
    parameter int MAXK = 3,
    parameter int MAXW = 64,
    parameter int MAXH = 64,
    parameter int MAXS = 4
) (
    input logic               clk,
    input logic               reset,
    window_stream_gen_if.slave bus
);
    localparam int KW = $clog2(MAXK + 1);
    localparam int WW = $clog2(MAXW + 1);
    localparam int HW = $clog2(MAXH + 1);
    localparam int SW = $clog2(MAXS + 1);
    localparam int AW = $clog2(MAXW);

    typedef logic [CH*INW-1:0] pix_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [KW-1:0]      k;
    logic [WW-1:0]      w, col;
    logic [HW-1:0]      h, row;
    logic [SW-1:0]      s, col_ph, row_ph;
    logic               last_seen, cfg_ok, in_rdy, acc, qual, drain_ok, cfg_err_q;
    logic               ov;
    pix_t [MAXK*MAXK-1:0] win_nx, wout;

    pix_t lb    [MAXK-1][MAXW];
    pix_t colsr [MAXK-1][MAXK];
    pix_t cv    [MAXK];
    pix_t cw    [MAXK][MAXK];

    assign cfg_ok = (bus.cfg_k != '0) && (bus.cfg_k <= KW'(MAXK)) &&
                    (bus.cfg_w >= WW'(bus.cfg_k)) && (bus.cfg_w <= WW'(MAXW)) &&
                    (bus.cfg_h >= HW'(bus.cfg_k)) && (bus.cfg_h <= HW'(MAXH)) &&
                    (bus.cfg_s != '0) && (bus.cfg_s <= SW'(MAXS));

    assign acc  = bus.in_valid && in_rdy;
    // Phase counters are zero exactly on stride-aligned rows/columns past the K-1 border.
    assign qual = acc && (row >= HW'(k) - HW'(1)) && (col >= WW'(k) - WW'(1)) &&
                  (row_ph == '0) && (col_ph == '0);

    // Column vector at the current col: [0] is the incoming pixel, [d] is d rows above.
    always_comb begin
        cv[0] = bus.pixel_in;
        for (int d = 1; d < MAXK; d++) cv[d] = lb[d-1][col[AW-1:0]];
        cw[0] = cv;
        for (int t = 1; t < MAXK; t++) cw[t] = colsr[t-1];
    end

    always_comb begin
        win_nx = '0;
        for (int kk = 1; kk <= MAXK; kk++)
            if (k == KW'(kk))
                for (int i = 0; i < kk; i++)
                    for (int j = 0; j < kk; j++)
                        win_nx[i*MAXK+j] = cw[kk-1-j][kk-1-i];
    end

    // Line buffer and column history carry no reset; contents are qualified by the counters.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb[0][col[AW-1:0]] <= bus.pixel_in;
            for (int d = 1; d < MAXK-1; d++) lb[d][col[AW-1:0]] <= lb[d-1][col[AW-1:0]];
            colsr[0] <= cv;
            for (int t = 1; t < MAXK-1; t++) colsr[t] <= colsr[t-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.clr) state_nx = IDLE;
        else begin
            case (state)
                IDLE:    if (bus.start && cfg_ok) state_nx = RUN;
                RUN:     if (drain_ok) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k <= '0; w <= '0; h <= '0; s <= '0;
            col <= '0; row <= '0; col_ph <= '0; row_ph <= '0;
            last_seen <= 1'b0; cfg_err_q <= 1'b0;
        end else if (bus.clr) begin
            k <= '0; w <= '0; h <= '0; s <= '0;
            col <= '0; row <= '0; col_ph <= '0; row_ph <= '0;
            last_seen <= 1'b0; cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state == IDLE) && bus.start && !cfg_ok;
            if (state == IDLE && bus.start && cfg_ok) begin
                k <= bus.cfg_k; w <= bus.cfg_w; h <= bus.cfg_h; s <= bus.cfg_s;
                col <= '0; row <= '0; col_ph <= '0; row_ph <= '0;
                last_seen <= 1'b0;
            end else if (acc) begin
                if (row == h - HW'(1) && col == w - WW'(1)) last_seen <= 1'b1;
                if (col == w - WW'(1)) begin
                    col    <= '0;
                    col_ph <= '0;
                    row    <= row + HW'(1);
                    if (row >= HW'(k) - HW'(1))
                        row_ph <= (row_ph == s - SW'(1)) ? '0 : row_ph + SW'(1);
                end else begin
                    col <= col + WW'(1);
                    if (col >= WW'(k) - WW'(1))
                        col_ph <= (col_ph == s - SW'(1)) ? '0 : col_ph + SW'(1);
                end
            end
        end
    end

`ifdef WINDOW_OUTREG_EN
    // Windows flow through stage p into the output register; the skid slot absorbs
    // one window while the output is stalled, so in_ready only looks at skid occupancy.
    logic pv, sk_v, fire, p_moved;
    pix_t [MAXK*MAXK-1:0] p_win, sk_win;

    assign fire     = !ov || bus.out_ready;
    assign p_moved  = pv && (fire || !sk_v);
    assign in_rdy   = (state == RUN) && !last_seen && !sk_v;
    assign drain_ok = last_seen && !pv && !sk_v && (!ov || bus.out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov <= 1'b0; wout <= '0; pv <= 1'b0; p_win <= '0; sk_v <= 1'b0; sk_win <= '0;
        end else if (bus.clr) begin
            ov <= 1'b0; wout <= '0; pv <= 1'b0; p_win <= '0; sk_v <= 1'b0; sk_win <= '0;
        end else begin
            if (fire) begin
                if (sk_v) begin
                    ov <= 1'b1; wout <= sk_win;
                    sk_v <= pv; sk_win <= p_win;
                end else if (pv) begin
                    ov <= 1'b1; wout <= p_win;
                end else begin
                    ov <= 1'b0;
                end
            end else if (pv && !sk_v) begin
                sk_v <= 1'b1; sk_win <= p_win;
            end
            if (qual) begin
                pv <= 1'b1; p_win <= win_nx;
            end else if (p_moved) begin
                pv <= 1'b0;
            end
        end
    end
`else
    assign in_rdy   = (state == RUN) && !last_seen && !(ov && !bus.out_ready);
    assign drain_ok = last_seen && (!ov || bus.out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov <= 1'b0; wout <= '0;
        end else if (bus.clr) begin
            ov <= 1'b0; wout <= '0;
        end else if (qual) begin
            ov <= 1'b1; wout <= win_nx;
        end else if (bus.out_ready) begin
            ov <= 1'b0;
        end
    end
`endif

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = ov;
    assign bus.window_out = wout;
    assign bus.frame_done = (state == DONE);
    assign bus.cfg_err    = cfg_err_q;
endmodule

// File: doc/window_stream_gen.md
Name: window_stream_gen

Overview:
- Sliding-window generator for the conv accelerator datapath. Successor to the fixed-width line-buffer window.
- Takes a raster-order multi-channel pixel stream and emits KxK windows (K runtime-selectable up to MAXK).
- Supports runtime row width, frame height and stride, with valid/ready flow control on both sides.
- Sits between the AXI-Stream input unpacker and the MAC array.

Parameters:
- INW, 16, bits per channel sample
- CH, 4, channels per pixel
- MAXK, 3, maximum kernel size
- MAXW, 64, maximum row width in pixels
- MAXH, 64, maximum frame height in rows
- MAXS, 4, maximum stride

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- clr  in  1  sync flush to IDLE, config discarded
- start  in  1  latch cfg_* (honoured only in IDLE)
- cfg_k  in  clog2(MAXK+1)  kernel size K
- cfg_w  in  clog2(MAXW+1)  row width W
- cfg_h  in  clog2(MAXH+1)  frame height H
- cfg_s  in  clog2(MAXS+1)  stride S
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid&&in_ready
- pixel_in  in  CH*INW  channel ch at bits [ch*INW +: INW]
- out_valid  out  1  window valid
- out_ready  in  1  window consumed when out_valid&&out_ready
- window_out  out  MAXK*MAXK*CH*INW  element (i,j,ch) at bits [((i*MAXK+j)*CH+ch)*INW +: INW]
- frame_done  out  1  one-cycle pulse at end of frame
- cfg_err  out  1  one-cycle pulse when start carries an illegal config

Behaviour:
- Clock, reset: one clock clk; reset is asynchronous and active-high.
- Reset values: state=IDLE, counters 0, in_ready=0, out_valid=0, window_out=0, frame_done=0, cfg_err=0.
- Line storage contents are don't-care after reset.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start with a legal config latches K, W, H, S and moves to RUN.
  - Legal config: 1<=K<=MAXK, K<=W<=MAXW, K<=H<=MAXH, 1<=S<=MAXS.
  - Otherwise cfg_err pulses the next cycle and the FSM stays in IDLE.
- RUN, input side:
  - in_ready = !(out_valid && !out_ready).
  - Each accepted pixel advances col (0..W-1, wraps to 0 and increments row, 0..H-1).
- RUN, window qualification:
  - A pixel accepted at (row r, col c) qualifies when r>=K-1, c>=K-1, (r-K+1)%S==0 and (c-K+1)%S==0.
  - Stride is handled with wrap counters, not dividers.
- RUN, output side:
  - Latency: the cycle after a qualifying accept, out_valid=1.
  - window_out(i,j) = pixel(r-K+1+i, c-K+1+j) for i,j<K. [0][0] is the oldest (top-left) pixel.
  - Elements with i>=K or j>=K are 0.
- Output hold and clear:
  - window_out and out_valid are held stable while out_valid&&!out_ready.
  - out_valid clears on handshake unless a new qualifying pixel is accepted in the same cycle, in which case the new window loads.
- RUN to DONE: after the pixel at (H-1, W-1) is accepted and the final window has handshaken.
- DONE: frame_done pulses for one cycle, then the FSM returns to IDLE with in_ready=0.
- start while in RUN or DONE is ignored.
- clr has priority over start and over data. The next cycle: IDLE, out_valid=0, counters 0. Any pending window is dropped.
- Line buffer storage is (MAXK-1) rows of MAXW pixels, addressed circularly by col. Only the first W entries are used, and K-1 rows are tapped.

Optional Feature:
- Macro: WINDOW_OUTREG_EN.
- Defined: an extra output register slice is added, so window latency becomes 2 cycles after the qualifying accept. in_ready is derived from the skid slot (full throughput, no combinational path from out_ready to in_ready). Handshake semantics are unchanged.
- Undefined: latency is 1 cycle and in_ready depends combinationally on out_ready, as stated above.

Test Plan:
- K=3, W=4, H=4, S=1, pixels 0..15, out_ready=1 -> 4 windows.
  - First window {0,1,2;4,5,6;8,9,10} with out_valid the cycle after pixel 10 is accepted.
  - Last window {5,6,7;9,10,11;13,14,15}. frame_done follows.
- K=3, W=5, H=5, S=2, pixels 0..24 -> exactly 4 windows, with top-left pixels 0, 2, 10, 12.
- K=2 with MAXK=3, W=3, H=3 -> first window {0,1;3,4}. Row 2 and column 2 of window_out are all 0.
- Scenario 1 with out_ready low for 5 cycles at the first window -> in_ready=0 and window_out stable throughout. No pixel or window lost; the window sequence is unchanged.
- start with K=0, then W=2 with K=3 -> cfg_err pulses each time, FSM stays IDLE, in_ready=0.
- Mid-frame disruption:
  - reset asserted after pixel 7 -> immediate IDLE with all outputs 0.
  - clr mid-frame -> same result next cycle.
  - Scenario 1 rerun afterwards gives identical windows.
